// File: rtl/nubus_test_master.sv
// NuBus test master: queues commands and runs single-word NuBus beats (START/DATA/ACK),
// returning one response per beat through a one-entry holding register.
module nubus_test_master #(
   parameter int CMD_DEPTH    = 4,
   parameter int CNT_W        = 4,
   parameter int TIMEOUT_CLKS = 255
) (
   input  logic             nub_clkn,
   input  logic             nub_resetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_tmad,
   input  logic [31:0]      cmd_addr,
   input  logic [31:0]      cmd_wdata,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_addr,
   output logic [31:0]      rsp_rdata,
   output logic [1:0]       rsp_status,
   output logic             rsp_timeout,
   output logic             busy,
   output logic             nub_startn_o,
   output logic [31:0]      nub_adn_o,
   output logic             nub_ad_oe,
   output logic [1:0]       nub_tmn_o,
   output logic             nub_tm_oe,
   input  logic [31:0]      nub_adn_i,
   input  logic [1:0]       nub_tmn_i,
   input  logic             nub_ackn_i
);

   localparam int              PTR_W     = $clog2(CMD_DEPTH);
   localparam logic [PTR_W:0]  FIFO_FULL = (PTR_W+1)'(CMD_DEPTH);
   localparam logic [15:0]     TMO_LAST  = 16'(TIMEOUT_CLKS - 1);

   typedef struct packed {
      logic [3:0]       tmad;
      logic [29:0]      word;
      logic [31:0]      wdata;
      logic [CNT_W-1:0] count;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_RESP} state_t;

   cmd_t             fifo_mem [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   fill_q, fill_d;
   logic             push, pop;

   state_t           state_q, state_d;
   cmd_t             cur_q, cur_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [15:0]      tmo_q, tmo_d;
   logic [31:0]      cap_rdata_q, cap_rdata_d;
   logic [1:0]       cap_status_q, cap_status_d;
   logic             cap_timeout_q, cap_timeout_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_addr_q, rsp_addr_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic [1:0]       rsp_status_q, rsp_status_d;
   logic             rsp_timeout_q, rsp_timeout_d;

   logic [29:0]      beat_word;
   logic [31:0]      beat_wdata;
   logic             is_write;
   logic             unused_addr_bits;

   // Full is judged on the registered fill level, so a same-cycle pop never makes room.
   assign cmd_ready        = (fill_q != FIFO_FULL);
   assign push             = cmd_valid && cmd_ready;
   assign unused_addr_bits = ^cmd_addr[1:0];

   assign beat_word  = cur_q.word + 30'(beat_q);
   assign beat_wdata = cur_q.wdata + 32'(beat_q);
   assign is_write   = cur_q.tmad[3];

   always_comb begin
      fill_d = fill_q;
      case ({push, pop})
         2'b10:   fill_d = fill_q + (PTR_W+1)'(1);
         2'b01:   fill_d = fill_q - (PTR_W+1)'(1);
         default: fill_d = fill_q;
      endcase
   end

   // NOTE: command storage has no reset; fill_q/pointers alone decide which entries are live.
   always_ff @(posedge nub_clkn) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= cmd_t'{tmad: cmd_tmad, word: cmd_addr[31:2],
                                      wdata: cmd_wdata, count: cmd_count};
      end
   end

   // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      beat_d        = beat_q;
      tmo_d         = tmo_q;
      cap_rdata_d   = cap_rdata_q;
      cap_status_d  = cap_status_q;
      cap_timeout_d = cap_timeout_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_addr_d    = rsp_addr_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_status_d  = rsp_status_q;
      rsp_timeout_d = rsp_timeout_q;
      pop           = 1'b0;

      if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fill_q != '0) begin
               pop     = 1'b1;
               cur_d   = fifo_mem[rd_ptr_q];
               beat_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            tmo_d   = '0;
            state_d = S_DATA;
         end
         S_DATA: begin
            if (!nub_ackn_i) begin
               cap_rdata_d   = is_write ? 32'h0 : ~nub_adn_i;
               cap_status_d  = ~nub_tmn_i;
               cap_timeout_d = 1'b0;
               state_d       = S_RESP;
            end else if (tmo_q == TMO_LAST) begin
               cap_rdata_d   = 32'h0;
               cap_status_d  = 2'b00;
               cap_timeout_d = 1'b1;
               state_d       = S_RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_RESP: begin
            // Holding register is free, or being drained this cycle: hand the beat over.
            if (!rsp_valid_q || rsp_ready) begin
               rsp_valid_d   = 1'b1;
               rsp_addr_d    = {beat_word, cur_q.tmad[1:0]};
               rsp_rdata_d   = cap_rdata_q;
               rsp_status_d  = cap_status_q;
               rsp_timeout_d = cap_timeout_q;
               if ((beat_q < cur_q.count) && !cap_timeout_q) begin
                  beat_d  = beat_q + CNT_W'(1);
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      nub_startn_o = 1'b1;
      nub_ad_oe    = 1'b0;
      nub_tm_oe    = 1'b0;
      nub_adn_o    = '1;
      nub_tmn_o    = '1;
      case (state_q)
         S_START: begin
            nub_startn_o = 1'b0;
            nub_ad_oe    = 1'b1;
            nub_tm_oe    = 1'b1;
            nub_adn_o    = ~{beat_word, cur_q.tmad[1:0]};
            nub_tmn_o    = ~cur_q.tmad[3:2];
         end
         S_DATA: begin
            if (is_write) begin
               nub_ad_oe = 1'b1;
               nub_adn_o = ~beat_wdata;
            end
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fill_q        <= '0;
         state_q       <= S_IDLE;
         cur_q         <= '0;
         beat_q        <= '0;
         tmo_q         <= '0;
         cap_rdata_q   <= '0;
         cap_status_q  <= '0;
         cap_timeout_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_addr_q    <= '0;
         rsp_rdata_q   <= '0;
         rsp_status_q  <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         fill_q        <= fill_d;
         state_q       <= state_d;
         cur_q         <= cur_d;
         beat_q        <= beat_d;
         tmo_q         <= tmo_d;
         cap_rdata_q   <= cap_rdata_d;
         cap_status_q  <= cap_status_d;
         cap_timeout_q <= cap_timeout_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_addr_q    <= rsp_addr_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_status_q  <= rsp_status_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_addr    = rsp_addr_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_status  = rsp_status_q;
   assign rsp_timeout = rsp_timeout_q;
   assign busy        = (state_q != S_IDLE) || (fill_q != '0);

endmodule
